// File: rtl/digito_pkg.sv
// Shared constants, types and template table for the digit-distance stage.
// The ten stored glyphs live here so the ROM and any later stage agree on them.
package digito_pkg;

    localparam int N_DIGITS = 10;
    localparam int PIX_W    = 8;
    localparam int DIST_W   = 16;
    localparam int N_PIX    = 64;
    localparam int ADDR_W   = $clog2(N_PIX);

    typedef logic [DIST_W-1:0] dist_t;
    typedef logic [PIX_W-1:0]  pix_t;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DRAIN,
        DONE
    } state_t;

    typedef logic [N_PIX-1:0][N_DIGITS-1:0][PIX_W-1:0] tpl_table_t;

    // Glyph set: digit 3 is fully dark, every other digit fully white.
    function automatic tpl_table_t build_templates();
        tpl_table_t t;
        for (int i = 0; i < N_PIX; i++) begin
            for (int d = 0; d < N_DIGITS; d++) begin
                t[i][d] = (d == 3) ? '0 : '1;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/template_rom.sv
// Ten-digit template ROM: one pixel per digit at the given raster index,
// returned one cycle after the address is presented.
module template_rom
    import digito_pkg::*;
(
    input  logic                              clk,
    input  logic [ADDR_W-1:0]                 addr,
    output logic [N_DIGITS-1:0][PIX_W-1:0]    tpl
);

    localparam tpl_table_t TPL = build_templates();

    always_ff @(posedge clk) begin
        tpl <= TPL[addr];
    end

endmodule

// File: rtl/distancia_templates.sv
// Per-digit sum-of-absolute-differences between an incoming 8x8 glyph and ten
// stored templates; pulses flag once the ten distances are final.
module distancia_templates
    import digito_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    output logic [DIST_W-1:0] v_diferenca [N_DIGITS-1:0],
    output logic              flag
);

    state_t                       state;
    state_t                       state_next;
    logic [ADDR_W-1:0]            idx;
    logic [ADDR_W-1:0]            pix_idx;
    logic [1:0]                   drain_cnt;
    logic                         xfer;
    logic                         sof_xfer;
    logic                         data_xfer;
    logic                         s0_valid;
    logic                         s1_valid;
    logic [PIX_W-1:0]             s0_pix;
    logic [PIX_W-1:0]             s1_pix;
    logic [ADDR_W-1:0]            s0_idx;
    logic [N_DIGITS-1:0][PIX_W-1:0] tpl;

    assign pix_ready = (state == IDLE) || (state == RECV);
    assign xfer      = pix_valid && pix_ready;
    assign sof_xfer  = xfer && pix_sof;
    assign data_xfer = sof_xfer || (xfer && (state == RECV));
    assign pix_idx   = pix_sof ? '0 : idx;
    assign flag      = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The drain lasts until the last pixel has landed in the accumulators
    // and has been visible for a full cycle before flag rises.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sof_xfer) state_next = RECV;
            RECV:    if (xfer && !pix_sof && (idx == ADDR_W'(N_PIX - 1))) state_next = DRAIN;
            DRAIN:   if (drain_cnt == 2'd2) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            drain_cnt <= '0;
            s0_valid  <= 1'b0;
            s1_valid  <= 1'b0;
            s0_pix    <= '0;
            s1_pix    <= '0;
            s0_idx    <= '0;
        end else begin
            s0_valid  <= data_xfer;
            if (data_xfer) begin
                s0_pix <= pix_data;
                s0_idx <= pix_idx;
                idx    <= pix_idx + 1'b1;
            end
            // An aborting SOF kills whatever older pixel is still in flight.
            s1_valid  <= s0_valid && !sof_xfer;
            s1_pix    <= s0_pix;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
        end
    end

    template_rom u_rom (
        .clk  (clk),
        .addr (s0_idx),
        .tpl  (tpl)
    );

    for (genvar d = 0; d < N_DIGITS; d++) begin : g_digit
        logic [PIX_W-1:0] diff;
        logic [DIST_W:0]  sum;
        dist_t            acc;

        always_comb begin
            diff = (s1_pix >= tpl[d]) ? (s1_pix - tpl[d]) : (tpl[d] - s1_pix);
            sum  = {1'b0, acc} + (DIST_W + 1)'(diff);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc <= '0;
            end else if (sof_xfer) begin
                acc <= '0;
            end else if (s1_valid) begin
                acc <= sum[DIST_W] ? '1 : sum[DIST_W-1:0];
            end
        end

        assign v_diferenca[d] = acc;
    end

endmodule
